// File: rtl/ekf_pkg.sv
// Shared stage codes, widths and FSM state set for the EKF-SLAM epoch sequencer.
package ekf_pkg;

    localparam int RSA_DW  = 32;
    localparam int ROW_LEN = 10;

    typedef enum logic [2:0] {
        STG_IDLE  = 3'd0,
        STG_PRD   = 3'd1,
        STG_NEW   = 3'd2,
        STG_UPD   = 3'd3,
        STG_ASSOC = 3'd4
    } stage_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRD_ISS,
        S_PRD_WAIT,
        S_OBS_WAIT,
        S_ASC_ISS,
        S_ASC_WAIT,
        S_NEW_ISS,
        S_UPD_ISS,
        S_MAP_WAIT,
        S_NEXT,
        S_ERR
    } state_e;

    function automatic logic is_iss(input state_e s);
        return (s == S_PRD_ISS) || (s == S_ASC_ISS) || (s == S_NEW_ISS) || (s == S_UPD_ISS);
    endfunction

    // NEW and UPD both complete through the shared map-wait state.
    function automatic state_e wait_of(input state_e s);
        case (s)
            S_PRD_ISS: return S_PRD_WAIT;
            S_ASC_ISS: return S_ASC_WAIT;
            default:   return S_MAP_WAIT;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ekf_stage_scheduler.sv
// Sequences the EKF-SLAM core through one filter epoch: PRD per odometry sample,
// then ASSOC per observation followed by NEW or UPD, with a stage_rdy watchdog.
//
// state      | meaning
// S_IDLE     | waiting for odometry (odom_ready=1)
// S_PRD_ISS  | stage_val=PRD for STAGE_HOLD cycles
// S_PRD_WAIT | waiting for stage_rdy==PRD
// S_OBS_WAIT | waiting for an observation (obs_ready=1)
// S_ASC_ISS  | stage_val=ASSOC for STAGE_HOLD cycles
// S_ASC_WAIT | waiting for stage_rdy==ASSOC and its result
// S_NEW_ISS  | stage_val=NEW, l_k=landmark_num
// S_UPD_ISS  | stage_val=UPD, l_k=assoc_idx
// S_MAP_WAIT | waiting for stage_rdy==NEW/UPD
// S_NEXT     | end of observation: next obs or end of epoch
// S_ERR      | watchdog expired, absorbing until sys_rst
module ekf_stage_scheduler
    import ekf_pkg::*;
#(
    parameter int MAX_LM     = 16,
    parameter int STAGE_HOLD = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               odom_valid,
    output logic               odom_ready,
    input  logic [RSA_DW-1:0]  odom_vlr,
    input  logic [RSA_DW-1:0]  odom_alpha,
    input  logic               odom_no_obs,
    input  logic               obs_valid,
    output logic               obs_ready,
    input  logic [RSA_DW-1:0]  obs_rk,
    input  logic [RSA_DW-1:0]  obs_phi,
    input  logic               obs_last,
    input  logic               assoc_is_new,
    input  logic [ROW_LEN-1:0] assoc_idx,
    output logic [2:0]         stage_val,
    input  logic [2:0]         stage_rdy,
    output logic [RSA_DW-1:0]  vlr,
    output logic [RSA_DW-1:0]  alpha,
    output logic [RSA_DW-1:0]  rk,
    output logic [RSA_DW-1:0]  phi,
    output logic [ROW_LEN-1:0] l_k,
    output logic [ROW_LEN-1:0] landmark_num,
    output logic               epoch_done,
    output logic               busy,
    output logic [7:0]         drop_cnt,
    output logic               err
);

    localparam logic [7:0]         HOLD_INIT = 8'(STAGE_HOLD - 1);
    localparam logic [15:0]        WD_INIT   = 16'(TIMEOUT - 1);
    localparam logic [ROW_LEN-1:0] LM_CAP    = ROW_LEN'(MAX_LM);

    state_e      state;
    stage_e      cur_code;
    logic        no_obs_q;
    logic        last_q;
    logic [7:0]  hold_cnt;
    logic [15:0] wd_cnt;

    // Readies and busy decode the state register only, so no input reaches them combinationally.
    assign odom_ready = (state == S_IDLE);
    assign obs_ready  = (state == S_OBS_WAIT);
    assign busy       = (state != S_IDLE) && (state != S_ERR);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            cur_code     <= STG_IDLE;
            stage_val    <= STG_IDLE;
            no_obs_q     <= 1'b0;
            last_q       <= 1'b0;
            hold_cnt     <= '0;
            wd_cnt       <= '0;
            vlr          <= '0;
            alpha        <= '0;
            rk           <= '0;
            phi          <= '0;
            l_k          <= '0;
            landmark_num <= '0;
            epoch_done   <= 1'b0;
            drop_cnt     <= '0;
            err          <= 1'b0;
        end else begin
            epoch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (odom_valid) begin
                        vlr       <= odom_vlr;
                        alpha     <= odom_alpha;
                        no_obs_q  <= odom_no_obs;
                        state     <= S_PRD_ISS;
                        cur_code  <= STG_PRD;
                        stage_val <= STG_PRD;
                        hold_cnt  <= HOLD_INIT;
                        wd_cnt    <= WD_INIT;
                    end
                end

                S_OBS_WAIT: begin
                    if (obs_valid) begin
                        rk        <= obs_rk;
                        phi       <= obs_phi;
                        last_q    <= obs_last;
                        state     <= S_ASC_ISS;
                        cur_code  <= STG_ASSOC;
                        stage_val <= STG_ASSOC;
                        hold_cnt  <= HOLD_INIT;
                        wd_cnt    <= WD_INIT;
                    end
                end

                S_PRD_ISS, S_ASC_ISS, S_NEW_ISS, S_UPD_ISS,
                S_PRD_WAIT, S_ASC_WAIT, S_MAP_WAIT: begin
                    if (stage_rdy == cur_code) begin
                        // Completion wins over both the hold timer and the watchdog.
                        stage_val <= STG_IDLE;
                        hold_cnt  <= HOLD_INIT;
                        wd_cnt    <= WD_INIT;
                        case (cur_code)
                            STG_PRD: begin
                                if (no_obs_q) begin
                                    state      <= S_IDLE;
                                    epoch_done <= 1'b1;
                                end else begin
                                    state <= S_OBS_WAIT;
                                end
                            end
                            STG_ASSOC: begin
                                if (assoc_is_new && (landmark_num < LM_CAP)) begin
                                    l_k       <= landmark_num;
                                    state     <= S_NEW_ISS;
                                    cur_code  <= STG_NEW;
                                    stage_val <= STG_NEW;
                                end else if (assoc_is_new) begin
                                    drop_cnt <= sat_inc8(drop_cnt);
                                    state    <= S_NEXT;
                                end else begin
                                    l_k       <= assoc_idx;
                                    state     <= S_UPD_ISS;
                                    cur_code  <= STG_UPD;
                                    stage_val <= STG_UPD;
                                end
                            end
                            STG_NEW: begin
                                if (landmark_num < LM_CAP) begin
                                    landmark_num <= landmark_num + ROW_LEN'(1);
                                end
                                state <= S_NEXT;
                            end
                            default: state <= S_NEXT;
                        endcase
                    end else if (wd_cnt == 16'd0) begin
                        err       <= 1'b1;
                        stage_val <= STG_IDLE;
                        state     <= S_ERR;
                    end else if (is_iss(state) && (hold_cnt == 8'd0)) begin
                        stage_val <= STG_IDLE;
                        state     <= wait_of(state);
                        wd_cnt    <= WD_INIT;
                    end else begin
                        wd_cnt <= wd_cnt - 16'd1;
                        if (is_iss(state)) begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                end

                S_NEXT: begin
                    if (last_q) begin
                        state      <= S_IDLE;
                        epoch_done <= 1'b1;
                    end else begin
                        state <= S_OBS_WAIT;
                    end
                end

                S_ERR: begin
                    stage_val <= STG_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ekf_stage_scheduler.sv
// Bench for ekf_stage_scheduler: scripted and randomized epochs against a map/drop model.
module tb_ekf_stage_scheduler;

    localparam int MAX_LM     = 16;
    localparam int STAGE_HOLD = 2;
    localparam int TIMEOUT    = 4096;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        odom_valid = 1'b0;
    logic        odom_ready;
    logic [31:0] odom_vlr = '0;
    logic [31:0] odom_alpha = '0;
    logic        odom_no_obs = 1'b0;
    logic        obs_valid = 1'b0;
    logic        obs_ready;
    logic [31:0] obs_rk = '0;
    logic [31:0] obs_phi = '0;
    logic        obs_last = 1'b0;
    logic        assoc_is_new = 1'b0;
    logic [9:0]  assoc_idx = '0;
    logic [2:0]  stage_val;
    logic [2:0]  stage_rdy = '0;
    logic [31:0] vlr, alpha, rk, phi;
    logic [9:0]  l_k, landmark_num;
    logic        epoch_done, busy, err;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: map size and dropped-landmark count
    int m_lm   = 0;
    int m_drop = 0;

    logic [31:0] exp_vlr, exp_alpha, exp_rk, exp_phi;
    logic        ep_new [8];
    logic [9:0]  ep_idx [8];
    logic [31:0] ep_rk  [8];
    logic [31:0] ep_phi [8];

    ekf_stage_scheduler #(
        .MAX_LM(MAX_LM), .STAGE_HOLD(STAGE_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .sys_rst(sys_rst),
        .odom_valid(odom_valid), .odom_ready(odom_ready),
        .odom_vlr(odom_vlr), .odom_alpha(odom_alpha), .odom_no_obs(odom_no_obs),
        .obs_valid(obs_valid), .obs_ready(obs_ready),
        .obs_rk(obs_rk), .obs_phi(obs_phi), .obs_last(obs_last),
        .assoc_is_new(assoc_is_new), .assoc_idx(assoc_idx),
        .stage_val(stage_val), .stage_rdy(stage_rdy),
        .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
        .l_k(l_k), .landmark_num(landmark_num),
        .epoch_done(epoch_done), .busy(busy), .drop_cnt(drop_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the core's side of one issued stage and checks what the scheduler presents.
    task automatic do_stage(input logic [2:0] code, input logic chk_lk, input logic [9:0] exp_lk,
                            input int delay, input logic spur, input logic early,
                            input logic a_new, input logic [9:0] a_idx);
        int t;
        int hold;
        logic [2:0] wrong;
        t = 0;
        while (stage_val == 3'd0 && t < 64) begin
            tick();
            t++;
        end
        n_checks++;
        if (stage_val !== code) begin
            n_fail++;
            $display("FAIL stage_code: got %0d expected %0d", stage_val, code);
        end
        n_checks++;
        if (vlr !== exp_vlr || alpha !== exp_alpha) begin
            n_fail++;
            $display("FAIL odom_data: got vlr=%0h alpha=%0h expected vlr=%0h alpha=%0h", vlr, alpha, exp_vlr, exp_alpha);
        end
        if (code != 3'd1) begin
            n_checks++;
            if (rk !== exp_rk || phi !== exp_phi) begin
                n_fail++;
                $display("FAIL obs_data: got rk=%0h phi=%0h expected rk=%0h phi=%0h", rk, phi, exp_rk, exp_phi);
            end
        end
        if (chk_lk) begin
            n_checks++;
            if (l_k !== exp_lk) begin
                n_fail++;
                $display("FAIL l_k_issue: got %0d expected %0d", l_k, exp_lk);
            end
        end
        if (early) begin
            stage_rdy    = code;
            assoc_is_new = a_new;
            assoc_idx    = a_idx;
            tick();
            stage_rdy    = 3'd0;
            assoc_is_new = ~a_new;
            assoc_idx    = 10'($urandom);
            n_checks++;
            if (stage_val === code) begin
                n_fail++;
                $display("FAIL iss_accept: got stage_val=%0d expected not %0d", stage_val, code);
            end
        end else begin
            hold = 0;
            while (stage_val == code && hold < 10) begin
                hold++;
                tick();
            end
            n_checks++;
            if (hold != STAGE_HOLD || stage_val !== 3'd0) begin
                n_fail++;
                $display("FAIL stage_hold: got %0d cycles (then %0d) expected %0d cycles (then 0)", hold, stage_val, STAGE_HOLD);
            end
            repeat (delay) tick();
            if (spur) begin
                wrong = (code == 3'd3) ? 3'd4 : 3'd3;
                stage_rdy = wrong;
                tick();
                stage_rdy = 3'd0;
                n_checks++;
                if (stage_val !== 3'd0 || busy !== 1'b1 || epoch_done !== 1'b0 || obs_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL spurious_rdy: got stage_val=%0d busy=%0b done=%0b obs_ready=%0b expected 0 1 0 0",
                             stage_val, busy, epoch_done, obs_ready);
                end
            end
            if (chk_lk) begin
                n_checks++;
                if (l_k !== exp_lk) begin
                    n_fail++;
                    $display("FAIL l_k_stable: got %0d expected %0d", l_k, exp_lk);
                end
            end
            stage_rdy    = code;
            assoc_is_new = a_new;
            assoc_idx    = a_idx;
            tick();
            stage_rdy    = 3'd0;
            assoc_is_new = ~a_new;
            assoc_idx    = 10'($urandom);
        end
    endtask

    task automatic send_odom(input logic [31:0] v, input logic [31:0] a, input logic no_obs);
        n_checks++;
        if (odom_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL odom_ready: got %0b expected 1", odom_ready);
        end
        odom_valid  = 1'b1;
        odom_vlr    = v;
        odom_alpha  = a;
        odom_no_obs = no_obs;
        exp_vlr     = v;
        exp_alpha   = a;
        tick();
        odom_valid  = 1'b0;
        odom_vlr    = $urandom;
        odom_alpha  = $urandom;
        odom_no_obs = ~no_obs;
    endtask

    task automatic send_obs(input logic [31:0] r, input logic [31:0] p, input logic last);
        int t;
        t = 0;
        while (obs_ready !== 1'b1 && t < 16) begin
            tick();
            t++;
        end
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL obs_ready: got %0b expected 1", obs_ready);
        end
        obs_valid = 1'b1;
        obs_rk    = r;
        obs_phi   = p;
        obs_last  = last;
        exp_rk    = r;
        exp_phi   = p;
        tick();
        obs_valid = 1'b0;
        obs_rk    = $urandom;
        obs_phi   = $urandom;
        obs_last  = ~last;
    endtask

    task automatic run_epoch(input logic [31:0] v, input logic [31:0] a, input int nobs,
                             input int prd_delay, input logic rnd);
        int t;
        send_odom(v, a, nobs == 0);
        do_stage(3'd1, 1'b0, 10'd0, prd_delay, rnd && $urandom_range(0, 2) == 0,
                 rnd && $urandom_range(0, 4) == 0, 1'b0, 10'd0);
        if (nobs == 0) begin
            n_checks++;
            if (epoch_done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL prd_epoch_done: got done=%0b busy=%0b expected 1 0", epoch_done, busy);
            end
        end else begin
            for (int i = 0; i < nobs; i++) begin
                send_obs(ep_rk[i], ep_phi[i], i == nobs - 1);
                do_stage(3'd4, 1'b0, 10'd0, rnd ? $urandom_range(0, 6) : 0,
                         rnd && $urandom_range(0, 2) == 0, rnd && $urandom_range(0, 4) == 0,
                         ep_new[i], ep_idx[i]);
                if (ep_new[i] && m_lm < MAX_LM) begin
                    do_stage(3'd2, 1'b1, 10'(m_lm), rnd ? $urandom_range(0, 6) : 0,
                             rnd && $urandom_range(0, 2) == 0, rnd && $urandom_range(0, 4) == 0,
                             1'b0, 10'd0);
                    m_lm++;
                end else if (ep_new[i]) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    do_stage(3'd3, 1'b1, ep_idx[i], rnd ? $urandom_range(0, 6) : 0,
                             rnd && $urandom_range(0, 2) == 0, rnd && $urandom_range(0, 4) == 0,
                             1'b0, 10'd0);
                end
            end
            t = 0;
            while (epoch_done !== 1'b1 && t < 4) begin
                tick();
                t++;
            end
            n_checks++;
            if (epoch_done !== 1'b1) begin
                n_fail++;
                $display("FAIL epoch_done: got %0b expected 1", epoch_done);
            end
        end
        n_checks++;
        if (landmark_num !== 10'(m_lm) || drop_cnt !== 8'(m_drop) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL epoch_totals: got lm=%0d drop=%0d err=%0b expected lm=%0d drop=%0d err=0",
                     landmark_num, drop_cnt, err, m_lm, m_drop);
        end
        tick();
        n_checks++;
        if (epoch_done !== 1'b0 || busy !== 1'b0 || odom_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL epoch_idle: got done=%0b busy=%0b odom_ready=%0b expected 0 0 1", epoch_done, busy, odom_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (stage_val !== 3'd0 || vlr !== '0 || alpha !== '0 || rk !== '0 || phi !== '0 ||
            l_k !== '0 || landmark_num !== '0 || epoch_done !== 1'b0 || busy !== 1'b0 ||
            drop_cnt !== '0 || err !== 1'b0 || obs_ready !== 1'b0 || odom_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got sv=%0d lk=%0d lm=%0d drop=%0d err=%0b busy=%0b done=%0b ordy=%0b brdy=%0b vlr=%0h expected all 0, odom_ready 1",
                     name, stage_val, l_k, landmark_num, drop_cnt, err, busy, epoch_done, odom_ready, obs_ready, vlr);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        m_lm = 0;
        m_drop = 0;
        check_reset_outputs("reset_state");
    endtask

    task automatic test_prd_only();
        run_epoch(32'(2) << 19, 32'(1) << 17, 0, 600, 1'b0);
    endtask

    task automatic test_new_landmark();
        ep_new[0] = 1'b1;
        ep_idx[0] = 10'd7;
        ep_rk[0]  = 32'd10730636;
        ep_phi[0] = -32'sd359159;
        run_epoch(32'h0010_0000, 32'h0002_0000, 1, 0, 1'b0);
        n_checks++;
        if (landmark_num !== 10'd1) begin
            n_fail++;
            $display("FAIL first_new_lm: got %0d expected 1", landmark_num);
        end
    endtask

    task automatic test_update();
        int guard;
        guard = 0;
        while (m_lm < 4 && guard < 8) begin
            ep_new[0] = 1'b1;
            ep_rk[0]  = $urandom;
            ep_phi[0] = $urandom;
            run_epoch($urandom, $urandom, 1, 0, 1'b0);
            guard++;
        end
        ep_new[0] = 1'b0;
        ep_idx[0] = 10'd2;
        ep_rk[0]  = $urandom;
        ep_phi[0] = $urandom;
        run_epoch($urandom, $urandom, 1, 0, 1'b0);
        n_checks++;
        if (landmark_num !== 10'd4) begin
            n_fail++;
            $display("FAIL upd_keeps_lm: got %0d expected 4", landmark_num);
        end
    endtask

    task automatic test_random_epochs();
        int nobs;
        for (int e = 0; e < 12; e++) begin
            nobs = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++) begin
                ep_new[i] = ($urandom_range(0, 1) == 1);
                ep_idx[i] = 10'($urandom_range(0, 15));
                ep_rk[i]  = $urandom;
                ep_phi[i] = $urandom;
            end
            run_epoch($urandom, $urandom, nobs, $urandom_range(0, 8), 1'b1);
        end
    endtask

    task automatic test_full_drop();
        int guard;
        guard = 0;
        while (m_lm < MAX_LM && guard < 20) begin
            for (int i = 0; i < 2; i++) begin
                ep_new[i] = 1'b1;
                ep_rk[i]  = $urandom;
                ep_phi[i] = $urandom;
            end
            run_epoch($urandom, $urandom, 2, 0, 1'b1);
            guard++;
        end
        ep_new[0] = 1'b1;
        ep_rk[0]  = $urandom;
        ep_phi[0] = $urandom;
        run_epoch($urandom, $urandom, 1, 0, 1'b0);
        n_checks++;
        if (landmark_num !== 10'(MAX_LM) || drop_cnt !== 8'(m_drop) || m_drop < 1) begin
            n_fail++;
            $display("FAIL full_drop: got lm=%0d drop=%0d expected lm=%0d drop=%0d", landmark_num, drop_cnt, MAX_LM, m_drop);
        end
        ep_new[0] = 1'b1;
        ep_new[1] = 1'b0;
        ep_idx[1] = 10'd15;
        ep_new[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ep_rk[i]  = $urandom;
            ep_phi[i] = $urandom;
        end
        run_epoch($urandom, $urandom, 3, 2, 1'b1);
    endtask

    task automatic test_reset_mid_epoch();
        int t;
        send_odom($urandom, $urandom, 1'b0);
        do_stage(3'd1, 1'b0, 10'd0, 1, 1'b0, 1'b0, 1'b0, 10'd0);
        send_obs($urandom, $urandom, 1'b1);
        do_stage(3'd4, 1'b0, 10'd0, 3, 1'b1, 1'b0, 1'b0, 10'd9);
        t = 0;
        while (stage_val == 3'd0 && t < 16) begin
            tick();
            t++;
        end
        n_checks++;
        if (stage_val !== 3'd3 || l_k !== 10'd9) begin
            n_fail++;
            $display("FAIL pre_reset_upd: got stage=%0d l_k=%0d expected 3 9", stage_val, l_k);
        end
        repeat (STAGE_HOLD + 2) tick();
        sys_rst = 1'b1;
        tick();
        m_lm = 0;
        m_drop = 0;
        check_reset_outputs("mid_epoch_reset");
        sys_rst = 1'b0;
        tick();
        check_reset_outputs("after_mid_reset");
    endtask

    task automatic test_timeout();
        int t;
        send_odom($urandom, $urandom, 1'b0);
        t = 0;
        while (stage_val == 3'd0 && t < 16) begin
            tick();
            t++;
        end
        t = 0;
        while (stage_val != 3'd0 && t < 16) begin
            tick();
            t++;
        end
        repeat (TIMEOUT - 1) tick();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got err=%0b busy=%0b expected 0 1", err, busy);
        end
        tick();
        n_checks++;
        if (err !== 1'b1 || stage_val !== 3'd0 || odom_ready !== 1'b0 || obs_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%0b sv=%0d ordy=%0b brdy=%0b busy=%0b expected 1 0 0 0 0",
                     err, stage_val, odom_ready, obs_ready, busy);
        end
        odom_valid = 1'b1;
        stage_rdy  = 3'd1;
        repeat (5) tick();
        odom_valid = 1'b0;
        stage_rdy  = 3'd0;
        n_checks++;
        if (err !== 1'b1 || stage_val !== 3'd0 || odom_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%0b sv=%0d ordy=%0b expected 1 0 0", err, stage_val, odom_ready);
        end
        test_reset();
        ep_new[0] = 1'b1;
        ep_rk[0]  = $urandom;
        ep_phi[0] = $urandom;
        run_epoch($urandom, $urandom, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_prd_only();
        test_new_landmark();
        test_update();
        test_random_epochs();
        test_full_drop();
        test_reset_mid_epoch();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish within time limit");
        $fatal(1, "simulation time limit");
    end

endmodule
